dadda_mul_arbiter: RTL and testbench

- Shares one combinational signed Dadda multiplier core (`dadda`: ports x, y, z0, z1) between N_REQ requesters.
- Each requester has an independent valid/ready operand port.
- Block arbitrates round-robin, registers the granted operands, and performs the final carry-propagate add of z0 + z1 + CORR.
- Returns a registered product tagged with the requester ID. Sits between DSP lane front-ends and the shared multiplier tile.

---
 rtl/dadda_mul_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_dadda_mul_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_arbiter.sv
// Round-robin front end for one shared signed Dadda multiplier core.
// The block has a two-stage pipeline. Stage 1 holds the granted operands.
// Stage 2 holds the final carry-propagate sum z0 + z1 + CORR.
// Optional build macro: DADDA_ARB_FIXED_PRIO_EN selects fixed lowest-index
// priority in place of round-robin, and removes the pointer register.
// The shared core "dadda" is defined in this file after the top module.

module dadda_mul_arbiter #(
  parameter int              W     = 4,
  parameter int              N_REQ = 2,
  parameter logic [2*W-1:0]  CORR  = 8'h08
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W-1:0]         req_a,
  input  logic [N_REQ*W-1:0]         req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [2*W-1:0]             res_data,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic                       busy
);

  localparam int IdW = $clog2(N_REQ);

  logic           s1Valid_q, s1Valid_d;
  logic [W-1:0]   s1A_q, s1A_d, s1B_q, s1B_d;
  logic [IdW-1:0] s1Id_q, s1Id_d;
  logic           resValid_q, resValid_d;
  logic [2*W-1:0] resData_q, resData_d;
  logic [IdW-1:0] resId_q, resId_d;

  logic           adv1, adv2, grantValid, transfer;
  logic [IdW-1:0] grantIdx;
  logic [W-1:0]   grantA, grantB;
  logic [2*W-1:0] z0, z1, cpaSum;

  assign adv2     = !resValid_q || res_ready;
  assign adv1     = !s1Valid_q || adv2;
  assign transfer = !rst && adv1 && grantValid;

`ifdef DADDA_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so that the lowest valid index wins.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    grantA     = '0;
    grantB     = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        grantValid = 1'b1;
        grantIdx   = IdW'(j);
        grantA     = req_a[j*W +: W];
        grantB     = req_b[j*W +: W];
      end
    end
  end
`else
  logic [IdW-1:0] ptr_q, ptr_d;
  int             offset, bestOffset;

  // Round-robin: the valid requester nearest to the pointer (with wrap) wins.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    grantA     = '0;
    grantB     = '0;
    offset     = 0;
    bestOffset = N_REQ;
    for (int j = 0; j < N_REQ; j++) begin
      offset = (j + N_REQ - int'(ptr_q)) % N_REQ;
      if (req_valid[j] && (offset < bestOffset)) begin
        bestOffset = offset;
        grantValid = 1'b1;
        grantIdx   = IdW'(j);
        grantA     = req_a[j*W +: W];
        grantB     = req_b[j*W +: W];
      end
    end
  end

  // The pointer moves one past the winner only when a transfer happens.
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = (grantIdx == IdW'(N_REQ - 1)) ? '0 : grantIdx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // The ready is one-hot on the winner. It is suppressed while stage 1 is stalled or in reset.
  always_comb begin
    req_ready = '0;
    if (transfer) begin
      req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grantIdx;
    end
  end

  dadda #(
    .W    (W),
    .CORR (CORR)
  ) uDadda (
    .x  (s1A_q),
    .y  (s1B_q),
    .z0 (z0),
    .z1 (z1)
  );

  assign cpaSum = z0 + z1 + CORR;

  // Pipeline next-state. Stage 1 refills when it advances, and stage 2 captures the product.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1A_d      = s1A_q;
    s1B_d      = s1B_q;
    s1Id_d     = s1Id_q;
    resValid_d = resValid_q;
    resData_d  = resData_q;
    resId_d    = resId_q;
    if (adv1) begin
      s1Valid_d = transfer;
      if (transfer) begin
        s1A_d  = grantA;
        s1B_d  = grantB;
        s1Id_d = grantIdx;
      end
    end
    if (adv2) begin
      resValid_d = s1Valid_q;
      if (s1Valid_q) begin
        resData_d = cpaSum;
        resId_d   = s1Id_q;
      end
    end
  end

  // Pipeline registers. Reset discards any in-flight entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Id_q     <= '0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resId_q    <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s1Id_q     <= s1Id_d;
      resValid_q <= resValid_d;
      resData_q  <= resData_d;
      resId_q    <= resId_d;
    end
  end

  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_id    = resId_q;
  assign busy      = s1Valid_q | resValid_q;

endmodule

// Combinational signed multiplier core.
// It builds the Baugh-Wooley partial-product matrix and reduces it by carry-save
// to two rows. The property it guarantees is z0 + z1 + CORR == x*y (mod 2^2W).
// The difference between the Baugh-Wooley sign constant and CORR is folded in
// as an extra partial-product row.
module dadda #(
  parameter int             W    = 4,
  parameter logic [2*W-1:0] CORR = 8'h08
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] z0,
  output logic [2*W-1:0] z1
);

  localparam logic [2*W-1:0] BW_CONST  = ((2*W)'(1) << (2*W - 1)) | ((2*W)'(1) << W);
  localparam logic [2*W-1:0] ROW_CONST = BW_CONST - CORR;

  logic [2*W-1:0] ppRow [W+1];
  logic [2*W-1:0] sumRow, carryRow, nextSum;

  // Partial products. Bits that mix one sign bit with one non-sign bit are inverted.
  always_comb begin
    for (int j = 0; j < W; j++) begin
      ppRow[j] = '0;
      for (int i = 0; i < W; i++) begin
        if ((i == W - 1) != (j == W - 1)) begin
          ppRow[j][i+j] = ~(x[i] & y[j]);
        end else begin
          ppRow[j][i+j] = x[i] & y[j];
        end
      end
    end
    ppRow[W] = ROW_CONST;
  end

  // Full-adder compression of every row down to one sum row and one carry row.
  always_comb begin
    sumRow   = ppRow[0];
    carryRow = ppRow[1];
    nextSum  = '0;
    for (int k = 2; k <= W; k++) begin
      nextSum  = sumRow ^ carryRow ^ ppRow[k];
      carryRow = ((sumRow & carryRow) | (sumRow & ppRow[k]) | (carryRow & ppRow[k])) << 1;
      sumRow   = nextSum;
    end
  end

  assign z0 = sumRow;
  assign z1 = carryRow;

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Self-checking bench for dadda_mul_arbiter. It uses N_REQ=3 so that the
// non-power-of-two pointer wrap is exercised. Expected values come from a
// transaction model: integer products, a pointer, and an occupancy record.
// Compile with +define+DADDA_ARB_FIXED_PRIO_EN to check the fixed-priority build.

module tb_dadda_mul_arbiter;

  localparam int W    = 4;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a;
  logic [NREQ*W-1:0]    req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*W-1:0]       res_data;
  logic [IDW-1:0]       res_id;
  logic                 busy;

  dadda_mul_arbiter #(
    .W     (W),
    .N_REQ (NREQ),
    .CORR  (8'h08)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit             v;
    logic [2*W-1:0] data;
    int             id;
  } slot_t;

  int           testsRun = 0;
  int           testsFailed = 0;
  slot_t        mS1, mOut;
  int           mPtr;
  int           lastGrant;
  bit           pend [NREQ];
  logic [W-1:0] opA [NREQ];
  logic [W-1:0] opB [NREQ];
  bit           tbResReady;
  bit           tbRst;
  int           acceptCount;
  int           req1Grants;

  function automatic logic [2*W-1:0] refMul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    rst       = tbRst;
    res_ready = tbResReady;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pend[i];
      req_a[i*W +: W]    = opA[i];
      req_b[i*W +: W]    = opB[i];
    end
  endtask

  // Compare against the model, then step the model across the coming clock edge.
  task automatic checkOutput();
    int g;
    bit adv1, adv2;
    logic [NREQ-1:0] expReady;
    g = -1;
    if (tbRst) begin
      mS1  = '{v: 1'b0, data: '0, id: 0};
      mOut = '{v: 1'b0, data: '0, id: 0};
      mPtr = 0;
      lastGrant = -1;
      check("rst_req_ready", req_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_id", res_id, 0);
      return;
    end
    adv2 = !mOut.v || tbResReady;
    adv1 = !mS1.v || adv2;
    if (adv1) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (mPtr + k) % NREQ;
        if (pend[j] && g < 0) g = j;
      end
    end
    expReady = (g >= 0) ? (NREQ'(1) << g) : '0;
    check("req_ready", req_ready, expReady);
    check("res_valid", res_valid, mOut.v);
    check("busy", busy, mS1.v || mOut.v);
    if (mOut.v) begin
      check("res_data", res_data, mOut.data);
      check("res_id", res_id, mOut.id);
    end
    if (adv2) begin
      if (mS1.v) mOut = mS1;
      else mOut.v = 1'b0;
    end
    if (adv1) begin
      if (g >= 0) begin
        mS1 = '{v: 1'b1, data: refMul(opA[g], opB[g]), id: g};
        pend[g] = 1'b0;
`ifdef DADDA_ARB_FIXED_PRIO_EN
        mPtr = 0;
`else
        mPtr = (g + 1) % NREQ;
`endif
      end else begin
        mS1.v = 1'b0;
      end
    end
    lastGrant = g;
  endtask

  task automatic cycle();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput();
  endtask

  task automatic arm(input int r);
    if (!pend[r]) begin
      pend[r] = 1'b1;
      opA[r]  = W'($urandom);
      opB[r]  = W'($urandom);
    end
  endtask

  task automatic drain(input int n);
    tbResReady = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Issue one op into an empty pipeline and check the product against a literal.
  task automatic runOp(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] expData, input string tag);
    pend[r] = 1'b1;
    opA[r]  = a;
    opB[r]  = b;
    tbResReady = 1'b1;
    cycle();
    cycle();
    check({tag, "_not_early"}, res_valid, 0);
    cycle();
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_data"}, res_data, expData);
    check({tag, "_id"}, res_id, r);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbRst = 1'b1;
    tbResReady = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      opA[i]  = '0;
      opB[i]  = '0;
    end
    mS1 = '{v: 1'b0, data: '0, id: 0};
    mOut = '{v: 1'b0, data: '0, id: 0};
    mPtr = 0;
    applyStimulus();
    #1;
    checkOutput();
    cycle();
    cycle();
    tbRst = 1'b0;
    cycle();

    runOp(0, 4'd3, 4'd7, 8'h15, "mul_3x7");
    runOp(0, 4'd0, 4'd0, 8'h00, "mul_0x0");
    runOp(1, 4'hA, 4'hA, 8'h24, "mul_m6xm6");
    runOp(2, 4'h8, 4'h8, 8'h40, "mul_m8xm8");
    runOp(0, 4'h8, 4'h7, 8'hC8, "mul_m8x7");
    runOp(1, 4'hF, 4'h1, 8'hFF, "mul_m1x1");
    runOp(2, 4'h7, 4'h7, 8'h31, "mul_7x7");
    drain(3);

    // Contention between requesters 0 and 1.
    for (int c = 0; c < 10; c++) begin
      arm(0);
      arm(1);
      cycle();
    end
    drain(6);

    // Backpressure: at most two ops can be held while the output is blocked.
    tbResReady = 1'b0;
    acceptCount = 0;
    for (int c = 0; c < 5; c++) begin
      arm(0);
      arm(1);
      cycle();
      if ((req_ready & req_valid) != '0) acceptCount++;
    end
    check("bp_accepts", acceptCount, 2);
    drain(8);

    // Wrap-around: grant requester 1 alone first, then contend 0 against 2.
    pend[1] = 1'b1;
    opA[1]  = 4'd2;
    opB[1]  = 4'd5;
    cycle();
    req1Grants = 0;
    for (int c = 0; c < 8; c++) begin
      arm(0);
      arm(2);
      cycle();
      if (req_ready[1]) req1Grants++;
    end
    check("wrap_req1_never", req1Grants, 0);
    drain(6);

    // Random traffic with random output backpressure.
    for (int c = 0; c < 400; c++) begin
      tbResReady = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1) arm(i);
      end
      cycle();
    end
    drain(10);

    // Reset with both stages full. Nothing stale may appear afterwards.
    tbResReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      arm(0);
      arm(1);
      arm(2);
      cycle();
    end
    check("pre_reset_busy", busy, 1);
    tbRst = 1'b1;
    cycle();
    cycle();
    tbRst = 1'b0;
    tbResReady = 1'b1;
    arm(0);
    cycle();
    check("post_reset_grant0", req_ready, 3'b001);
    drain(8);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
